sram_arbiter: RTL and testbench

- Shares the single external 8-bit async SRAM between two requesters.
  - Port A: the ROM/disk loader.
  - Port B: the Spectrum core memory port.
- Sequences every SRAM cycle: address setup, WE strobe, data hold and bus turnaround.
- Sits between the loader/core and the SRAM pins in the board top level, replacing ad-hoc muxing of sramWe/sramDQ/sramA.

---
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the board's 8-bit async SRAM (A = ROM/disk loader, B = core).
// Owns every SRAM cycle: address setup, WE strobe, data hold and bus turnaround.
module sram_arbiter #(
  parameter int AW        = 21,
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lockA,
  input  logic          aReq,
  input  logic          aWr,
  input  logic [AW-1:0] aA,
  input  logic [7:0]    aD,
  output logic [7:0]    aQ,
  output logic          aAck,
  input  logic          bReq,
  input  logic          bWr,
  input  logic [AW-1:0] bA,
  input  logic [7:0]    bD,
  output logic [7:0]    bQ,
  output logic          bAck,
  output logic          busy,
  output logic          sramWe,
  inout  wire  [7:0]    sramDQ,
  output logic [AW-1:0] sramA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int CMAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef struct packed {
    logic          port_b;
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;

  req_t          req_q, req_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;
  logic [7:0]    aq_q, aq_d, bq_q, bq_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          busy_q, busy_d;
  logic          we_n_q, we_n_d;
  logic          oe_q, oe_d;
  logic          elig_b, gnt_b, gnt_any;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    last_b_d = last_b_q;
    aq_d     = aq_q;
    bq_d     = bq_q;
    // Tie goes to whichever port was not served last.
    elig_b   = bReq & ~lockA;
    gnt_b    = elig_b & (~aReq | ~last_b_q);
    gnt_any  = aReq | elig_b;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req_d.port_b = gnt_b;
          req_d.wr     = gnt_b ? bWr : aWr;
          req_d.addr   = gnt_b ? bA  : aA;
          req_d.data   = gnt_b ? bD  : aD;
          last_b_d     = gnt_b;
          state_d      = req_d.wr ? S_SETUP : S_READ;
          cnt_d        = req_d.wr ? CW'(WE_CYCLES - 1) : CW'(RD_CYCLES - 1);
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          if (req_q.port_b) bq_d = sramDQ;
          else              aq_d = sramDQ;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_HOLD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Pin controls are decoded from the next state so they leave a flop cleanly.
    a_ack_d = (state_d == S_DONE) & ~req_q.port_b;
    b_ack_d = (state_d == S_DONE) &  req_q.port_b;
    busy_d  = (state_d != S_IDLE);
    we_n_d  = (state_d != S_STROBE);
    oe_d    = (state_d == S_SETUP) | (state_d == S_STROBE) | (state_d == S_HOLD);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      last_b_q <= 1'b1;
      aq_q     <= '0;
      bq_q     <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      we_n_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      last_b_q <= last_b_d;
      aq_q     <= aq_d;
      bq_q     <= bq_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
      we_n_q   <= we_n_d;
      oe_q     <= oe_d;
    end
  end

  // Reset gates the strobe and bus drive directly so an abort never leaves a write half-done.
  assign sramWe = we_n_q | ~reset;
  assign sramDQ = (oe_q & reset) ? req_q.data : 8'hzz;
  assign sramA  = req_q.addr;
  assign aQ     = aq_q;
  assign bQ     = bq_q;
  assign aAck   = a_ack_q;
  assign bAck   = b_ack_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: SRAM pin model plus a transaction-timed reference
// that predicts grants, ack cycles, strobe and drive windows from the arbitration rules.
module tb_sram_arbiter;
  localparam int AW = 21;
  localparam int RD = 2;
  localparam int WE = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          lockA = 1'b0;
  logic          aReq = 1'b0, aWr = 1'b0, bReq = 1'b0, bWr = 1'b0;
  logic [AW-1:0] aA = '0, bA = '0;
  logic [7:0]    aD = '0, bD = '0;
  logic [7:0]    aQ, bQ;
  logic          aAck, bAck, busy, sramWe;
  logic [AW-1:0] sramA;
  wire  [7:0]    sramDQ;

  sram_arbiter #(.AW(AW), .RD_CYCLES(RD), .WE_CYCLES(WE)) dut (
    .clock(clock), .reset(reset), .lockA(lockA),
    .aReq(aReq), .aWr(aWr), .aA(aA), .aD(aD), .aQ(aQ), .aAck(aAck),
    .bReq(bReq), .bWr(bWr), .bA(bA), .bD(bD), .bQ(bQ), .bAck(bAck),
    .busy(busy), .sramWe(sramWe), .sramDQ(sramDQ), .sramA(sramA)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SRAM environment: reference contents and pin-level contents, same fill for untouched cells
  logic [7:0] sram_mem [logic [AW-1:0]];
  logic [7:0] ref_mem  [logic [AW-1:0]];
  int         mem_gen = 0;
  logic [7:0] drv_val = '0;
  bit         in_win = 1'b0;

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ {a[20:18], a[12:8]} ^ 8'h3C;
  endfunction
  function automatic logic [7:0] sram_rd(input logic [AW-1:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(sramA or mem_gen or cyc) drv_val = sram_rd(sramA);
  wire tb_en = !in_win || !reset;
  assign sramDQ = tb_en ? drv_val : 8'hzz;

  // Reference: one outstanding grant, described by its grant cycle and attributes
  int            nxt_free = 0, g_t = 0;
  bit            g_vld = 1'b0, g_port = 1'b0, g_wr = 1'b0, m_last_b = 1'b1;
  logic [AW-1:0] g_addr = '0, m_addr = '0;
  logic [7:0]    g_data = '0, g_rdata = '0, m_aq = '0, m_bq = '0;

  function automatic int ack_at();
    return g_t + (g_wr ? WE + 3 : RD + 1);
  endfunction
  function automatic bit win(input int c);
    return g_vld && g_wr && c >= g_t + 1 && c <= g_t + WE + 2;
  endfunction
  function automatic bit strobe(input int c);
    return g_vld && g_wr && c >= g_t + 2 && c <= g_t + WE + 1;
  endfunction
  function automatic bit active(input int c);
    return g_vld && c >= g_t + 1 && c <= ack_at();
  endfunction

  bit mon_on = 1'b0;
  int a_acks = 0, b_acks = 0, we_lows = 0;
  bit a_ack_seen = 1'b0, b_ack_seen = 1'b0;
  bit ack_log [$];
  int mc;
  bit e_ack, ea, eb, pb;

  always @(negedge clock) if (mon_on) begin
    mc = cyc;
    if (sramWe === 1'b0) begin
      sram_mem[sramA] = sramDQ;
      mem_gen++;
      we_lows++;
    end
    e_ack = g_vld && mc == ack_at();
    if (e_ack && !g_wr) begin
      if (g_port) m_bq = g_rdata;
      else        m_aq = g_rdata;
    end
    chk("aAck", aAck, e_ack && !g_port);
    chk("bAck", bAck, e_ack && g_port);
    chk("busy", busy, active(mc));
    chk("sramWe", sramWe, !(reset && strobe(mc)));
    chk("sramA", sramA, m_addr);
    chk("sramDQ", sramDQ, (reset && win(mc)) ? g_data : drv_val);
    chk("aQ", aQ, m_aq);
    chk("bQ", bQ, m_bq);
    chk("ack_has_req", (!aAck || aReq) && (!bAck || bReq), 1);
    if (aAck) begin a_acks++; a_ack_seen = 1'b1; ack_log.push_back(1'b0); end
    if (bAck) begin b_acks++; b_ack_seen = 1'b1; ack_log.push_back(1'b1); end
    if (!reset) begin
      g_vld = 1'b0; nxt_free = mc + 1; m_last_b = 1'b1;
      m_addr = '0; m_aq = '0; m_bq = '0;
    end else if (mc >= nxt_free) begin
      ea = aReq;
      eb = bReq && !lockA;
      if (ea || eb) begin
        pb     = eb && (!ea || !m_last_b);
        g_vld  = 1'b1;
        g_t    = mc;
        g_port = pb;
        g_wr   = pb ? bWr : aWr;
        g_addr = pb ? bA : aA;
        g_data = pb ? bD : aD;
        if (g_wr) ref_mem[g_addr] = g_data;
        else      g_rdata = ref_rd(g_addr);
        m_last_b = pb;
        m_addr   = g_addr;
        nxt_free = mc + (g_wr ? WE + 4 : RD + 2);
      end
    end
    in_win = win(mc + 1);
  end

  task automatic do_op(input bit port, input bit wr, input logic [AW-1:0] addr,
                       input logic [7:0] data, output logic [7:0] q, output int lat);
    int t0;
    bit got;
    @(posedge clock); #1;
    if (port) begin bReq = 1'b1; bWr = wr; bA = addr; bD = data; end
    else      begin aReq = 1'b1; aWr = wr; aA = addr; aD = data; end
    t0 = cyc; got = 1'b0; lat = -1; q = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (port ? bAck : aAck) begin
        got = 1'b1; lat = cyc - t0; q = port ? bQ : aQ;
      end
    end
    chk("op_ack", got, 1);
    @(posedge clock); #1;
    if (port) bReq = 1'b0; else aReq = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [7:0] q;
    int lat, w0, a0, b0, base, ia, ib, ra0, rb0;
    bit got;
    sram_mem[21'h00100] = 8'h5A;
    ref_mem[21'h00100]  = 8'h5A;
    mem_gen++;
    @(posedge clock); #1;
    mon_on = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", sramWe, 1);
    chk("rst_addr", sramA, 0);
    chk("rst_q", {aQ, bQ}, 0);
    reset = 1'b1;

    // Port A read
    w0 = we_lows;
    do_op(1'b0, 1'b0, 21'h00100, 8'h00, q, lat);
    chk("rd_lat", lat, RD + 1);
    chk("rd_data", q, 8'h5A);
    chk("rd_no_we", we_lows - w0, 0);

    // Port B write and read-back
    w0 = we_lows;
    do_op(1'b1, 1'b1, 21'h1C000, 8'hA5, q, lat);
    chk("wr_lat", lat, WE + 3);
    chk("wr_we_low", we_lows - w0, WE);
    do_op(1'b1, 1'b0, 21'h1C000, 8'h00, q, lat);
    chk("wr_readback", q, 8'hA5);

    // Both ports held: grants alternate starting with A (B served last)
    base = ack_log.size();
    @(posedge clock); #1;
    aReq = 1'b1; aWr = 1'b0; aA = 21'h5;
    bReq = 1'b1; bWr = 1'b0; bA = 21'h6;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (ack_log.size() >= base + 6) break;
    end
    aReq = 1'b0; bReq = 1'b0;
    chk("rr_count", ack_log.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < ack_log.size()) chk("rr_order", ack_log[base + i], i % 2);

    // lockA holds off B
    @(posedge clock); #1;
    lockA = 1'b1; bReq = 1'b1; bWr = 1'b0; bA = 21'h7;
    a0 = a_acks; b0 = b_acks;
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b0, AW'(i + 8), 8'h00, q, lat);
    chk("lock_a_acks", a_acks - a0, 3);
    chk("lock_b_acks", b_acks - b0, 0);
    @(posedge clock); #1;
    lockA = 1'b0;
    b0 = cyc; got = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (bAck) begin got = 1'b1; lat = cyc - b0; end
    end
    chk("unlock_b_ack", got && lat <= RD + 2, 1);
    @(posedge clock); #1;
    bReq = 1'b0;

    // Reset during STROBE aborts; held request completes once afterwards
    @(posedge clock); #1;
    aReq = 1'b1; aWr = 1'b1; aA = 21'h55; aD = 8'hC3;
    a0 = a_acks;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_we", sramWe, 1);
    chk("abort_dq", sramDQ, sram_rd(21'h55));
    repeat (2) @(posedge clock);
    #1;
    chk("abort_no_ack", a_acks - a0, 0);
    reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (aAck) got = 1'b1;
    end
    @(posedge clock); #1;
    aReq = 1'b0;
    repeat (4) @(posedge clock);
    chk("abort_one_ack", a_acks - a0, 1);
    do_op(1'b0, 1'b0, 21'h55, 8'h00, q, lat);
    chk("abort_readback", q, 8'hC3);

    // Random mixed traffic
    ra0 = a_acks; rb0 = b_acks; ia = 0; ib = 0;
    a_ack_seen = 1'b0; b_ack_seen = 1'b0;
    for (int k = 0; k < 80000 && ia + ib < 10000; k++) begin
      @(posedge clock); #1;
      if (aReq && a_ack_seen) aReq = 1'b0;
      if (bReq && b_ack_seen) bReq = 1'b0;
      a_ack_seen = 1'b0; b_ack_seen = 1'b0;
      if (!aReq && $urandom_range(0, 3) != 0) begin
        aReq = 1'b1; aWr = 1'($urandom_range(0, 1)); aA = rnd_addr(); aD = 8'($urandom); ia++;
      end else if (aReq && $urandom_range(0, 3) == 0) begin
        aA = rnd_addr(); aD = 8'($urandom);
      end
      if (!bReq && $urandom_range(0, 3) != 0) begin
        bReq = 1'b1; bWr = 1'($urandom_range(0, 1)); bA = rnd_addr(); bD = 8'($urandom); ib++;
      end else if (bReq && $urandom_range(0, 3) == 0) begin
        bA = rnd_addr(); bD = 8'($urandom);
      end
      if (lockA ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0)) lockA = !lockA;
    end
    chk("rand_issued", ia + ib >= 10000, 1);
    lockA = 1'b0;
    for (int k = 0; k < 200 && (aReq || bReq); k++) begin
      @(posedge clock); #1;
      if (aReq && a_ack_seen) aReq = 1'b0;
      if (bReq && b_ack_seen) bReq = 1'b0;
      a_ack_seen = 1'b0; b_ack_seen = 1'b0;
    end
    repeat (5) @(posedge clock);
    chk("rand_a_acks", a_acks - ra0, ia);
    chk("rand_b_acks", b_acks - rb0, ib);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
